mutative_fill_ctrl: RTL and testbench

Miss-handling and line-fill controller for the mutative cache, directly downstream of the PLRU replacement stage. On a tag-compare miss it latches the victim way chosen by replacement (`evict_way`/`evict_we`), optionally writes back a dirty victim, fetches the missing line from memory and installs it into the data/tag arrays with a one-cycle way-select write. The requester replays the access after `fill_done` and hits.

---
 rtl/mutative_fill_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mutative_fill_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mutative_fill_ctrl.sv
// Miss-handling / line-fill controller: latches the replacement victim, optionally writes back a
// dirty line (MUTATIVE_WRITEBACK_EN), fetches the missing line and installs it in one cycle.
module mutative_fill_ctrl #(
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned WAYS      = 8,
  parameter int unsigned SET_BITS  = 6,
  localparam int unsigned WAY_IDX_BITS = $clog2(WAYS),
  localparam int unsigned OFF_BITS     = $clog2(LINE_BITS / 8),
  localparam int unsigned TAG_BITS     = ADDR_BITS - SET_BITS - OFF_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_miss,
  input  logic [ADDR_BITS-1:0]    req_addr,
  input  logic [WAY_IDX_BITS-1:0] evict_way,
  input  logic [WAYS-1:0]         evict_we,
  input  logic                    victim_dirty,
  input  logic [TAG_BITS-1:0]     victim_tag,
  input  logic [LINE_BITS-1:0]    victim_data,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_BITS-1:0]    mem_addr,
  output logic [LINE_BITS-1:0]    mem_wdata,
  input  logic [LINE_BITS-1:0]    mem_rdata,
  input  logic                    mem_resp,
  output logic [WAYS-1:0]         fill_we,
  output logic [WAY_IDX_BITS-1:0] fill_way,
  output logic [SET_BITS-1:0]     fill_set,
  output logic [TAG_BITS-1:0]     fill_tag,
  output logic [LINE_BITS-1:0]    fill_data,
  output logic                    busy,
  output logic                    fill_done
);

  localparam int unsigned LINE_ADDR_BITS = ADDR_BITS - OFF_BITS;

  typedef enum logic [1:0] {StIdle, StWb, StFill, StInstall} state_e;

  state_e state_q, state_d;

  logic [LINE_ADDR_BITS-1:0] line_q, line_d;
  logic [WAY_IDX_BITS-1:0]   way_q, way_d;
  logic [WAYS-1:0]           we_q, we_d;

  logic                      mem_read_d;
  logic [ADDR_BITS-1:0]      mem_addr_d;
  logic [WAYS-1:0]           fill_we_d;
  logic [WAY_IDX_BITS-1:0]   fill_way_d;
  logic [SET_BITS-1:0]       fill_set_d;
  logic [TAG_BITS-1:0]       fill_tag_d;
  logic [LINE_BITS-1:0]      fill_data_d;
  logic                      busy_d;
  logic                      install;
  logic [WAYS-1:0]           way_mask_d, way_mask_q;

`ifdef MUTATIVE_WRITEBACK_EN
  logic [TAG_BITS-1:0]  vtag_q, vtag_d;
  logic [LINE_BITS-1:0] vdata_q, vdata_d;
  logic                 mem_write_d;
  logic [LINE_BITS-1:0] mem_wdata_d;
  logic                 unused_offset;
  assign unused_offset = ^req_addr[OFF_BITS-1:0];
`else
  logic unused_inputs;
  assign unused_inputs = ^{req_addr[OFF_BITS-1:0], victim_dirty, victim_tag, victim_data};
`endif

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    way_d   = way_q;
    we_d    = we_q;
`ifdef MUTATIVE_WRITEBACK_EN
    vtag_d  = vtag_q;
    vdata_d = vdata_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_miss) begin
          line_d = req_addr[ADDR_BITS-1:OFF_BITS];
          way_d  = evict_way;
          we_d   = evict_we;
`ifdef MUTATIVE_WRITEBACK_EN
          vtag_d  = victim_tag;
          vdata_d = victim_data;
          state_d = victim_dirty ? StWb : StFill;
`else
          state_d = StFill;
`endif
        end
      end
      StWb:      if (mem_resp) state_d = StFill;
      StFill:    if (mem_resp) state_d = StInstall;
      StInstall: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so every output is a plain register.
  always_comb begin
    way_mask_d  = {{(WAYS-1){1'b0}}, 1'b1} << way_d;
    install     = (state_d == StInstall);
    busy_d      = (state_d != StIdle);
    mem_read_d  = (state_d == StFill);
    mem_addr_d  = '0;
    if (state_d == StFill) mem_addr_d = {line_d, {OFF_BITS{1'b0}}};
`ifdef MUTATIVE_WRITEBACK_EN
    mem_write_d = (state_d == StWb);
    mem_wdata_d = '0;
    if (state_d == StWb) begin
      mem_addr_d  = {vtag_d, line_d[SET_BITS-1:0], {OFF_BITS{1'b0}}};
      mem_wdata_d = vdata_d;
    end
`endif
    // Way-select comes from the captured index; a malformed captured mask is never written.
    fill_we_d   = install ? way_mask_d : '0;
    fill_way_d  = install ? way_d : '0;
    fill_set_d  = install ? line_d[SET_BITS-1:0] : '0;
    fill_tag_d  = install ? line_d[LINE_ADDR_BITS-1 -: TAG_BITS] : '0;
    fill_data_d = install ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      line_q    <= '0;
      way_q     <= '0;
      we_q      <= '0;
      mem_read  <= 1'b0;
      mem_addr  <= '0;
      fill_we   <= '0;
      fill_way  <= '0;
      fill_set  <= '0;
      fill_tag  <= '0;
      fill_data <= '0;
      busy      <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      way_q     <= way_d;
      we_q      <= we_d;
      mem_read  <= mem_read_d;
      mem_addr  <= mem_addr_d;
      fill_we   <= fill_we_d;
      fill_way  <= fill_way_d;
      fill_set  <= fill_set_d;
      fill_tag  <= fill_tag_d;
      fill_data <= fill_data_d;
      busy      <= busy_d;
      fill_done <= install;
    end
  end

`ifdef MUTATIVE_WRITEBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      vtag_q    <= '0;
      vdata_q   <= '0;
      mem_write <= 1'b0;
      mem_wdata <= '0;
    end else begin
      vtag_q    <= vtag_d;
      vdata_q   <= vdata_d;
      mem_write <= mem_write_d;
      mem_wdata <= mem_wdata_d;
    end
  end
`else
  assign mem_write = 1'b0;
  assign mem_wdata = '0;
`endif

  assign way_mask_q = {{(WAYS-1){1'b0}}, 1'b1} << way_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && state_q == StInstall) begin
      assert (we_q == way_mask_q)
        else $error("evict_we %b inconsistent with evict_way %0d", we_q, way_q);
    end
  end
`endif

endmodule

// File: tb/tb_mutative_fill_ctrl.sv
// Self-checking bench for mutative_fill_ctrl: table-driven misses, randomized misses against a
// transaction-level expectation, and hand sequences for reset, back-to-back and stray responses.
module tb_mutative_fill_ctrl;

  localparam int LB = 256;
  localparam int AB = 32;
  localparam int NW = 8;
  localparam int SB = 6;
  localparam int OB = 5;
  localparam int TB = 21;
  localparam int WB = 3;
`ifdef MUTATIVE_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_miss;
  logic [AB-1:0] req_addr;
  logic [WB-1:0] evict_way;
  logic [NW-1:0] evict_we;
  logic          victim_dirty;
  logic [TB-1:0] victim_tag;
  logic [LB-1:0] victim_data;
  logic          mem_read, mem_write;
  logic [AB-1:0] mem_addr;
  logic [LB-1:0] mem_wdata, mem_rdata;
  logic          mem_resp;
  logic [NW-1:0] fill_we;
  logic [WB-1:0] fill_way;
  logic [SB-1:0] fill_set;
  logic [TB-1:0] fill_tag;
  logic [LB-1:0] fill_data;
  logic          busy, fill_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mutative_fill_ctrl #(
    .LINE_BITS (LB),
    .ADDR_BITS (AB),
    .WAYS      (NW),
    .SET_BITS  (SB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_miss     (req_miss),
    .req_addr     (req_addr),
    .evict_way    (evict_way),
    .evict_we     (evict_we),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .victim_data  (victim_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .fill_we      (fill_we),
    .fill_way     (fill_way),
    .fill_set     (fill_set),
    .fill_tag     (fill_tag),
    .fill_data    (fill_data),
    .busy         (busy),
    .fill_done    (fill_done)
  );

  typedef struct {
    logic [SB-1:0] set;
    logic [TB-1:0] tag;
    logic [WB-1:0] way;
    logic [WB-1:0] alt_way;
    logic          dirty;
    logic [TB-1:0] vtag;
    int            wb_delay;
    int            delay;
    logic [NW-1:0] exp_we;
  } vec_t;

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] v;
    for (int i = 0; i < LB / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("no_rw_overlap", LB'(mem_read & mem_write), '0);
  endtask

  task automatic chk_all_zero(input string tag_s);
    chk({tag_s, "_busy"}, LB'(busy), '0);
    chk({tag_s, "_mem_read"}, LB'(mem_read), '0);
    chk({tag_s, "_mem_write"}, LB'(mem_write), '0);
    chk({tag_s, "_mem_addr"}, LB'(mem_addr), '0);
    chk({tag_s, "_mem_wdata"}, mem_wdata, '0);
    chk({tag_s, "_fill_we"}, LB'(fill_we), '0);
    chk({tag_s, "_fill_done"}, LB'(fill_done), '0);
    chk({tag_s, "_fill_way"}, LB'(fill_way), '0);
    chk({tag_s, "_fill_set"}, LB'(fill_set), '0);
    chk({tag_s, "_fill_tag"}, LB'(fill_tag), '0);
    chk({tag_s, "_fill_data"}, fill_data, '0);
  endtask

  // One full miss; inputs are scrambled while busy to show they are ignored.
  task automatic do_miss(input vec_t v);
    logic [LB-1:0] vdata, rdata;
    logic [AB-1:0] fill_addr, wb_addr;
    logic          wb;
    vdata     = rand_line();
    rdata     = rand_line();
    wb        = v.dirty && WB_EN;
    fill_addr = {v.tag, v.set, {OB{1'b0}}};
    wb_addr   = {v.vtag, v.set, {OB{1'b0}}};
    req_valid    = 1'b1;
    req_miss     = 1'b1;
    req_addr     = {v.tag, v.set, 5'($urandom)};
    evict_way    = v.way;
    evict_we     = 8'b1 << v.way;
    victim_dirty = v.dirty;
    victim_tag   = v.vtag;
    victim_data  = vdata;
    tick();
    req_addr     = $urandom;
    evict_way    = v.alt_way;
    evict_we     = 8'b1 << v.alt_way;
    victim_dirty = ~v.dirty;
    victim_tag   = TB'($urandom);
    victim_data  = rand_line();
    chk("busy_rise", LB'(busy), LB'(1));
    if (wb) begin
      chk("wb_mem_write", LB'(mem_write), LB'(1));
      chk("wb_mem_read", LB'(mem_read), '0);
      chk("wb_mem_addr", LB'(mem_addr), LB'(wb_addr));
      chk("wb_mem_wdata", mem_wdata, vdata);
      for (int i = 0; i < v.wb_delay; i++) begin
        tick();
        chk("wb_hold", LB'({mem_write, mem_read}), LB'(2'b10));
        chk("wb_hold_addr", LB'(mem_addr), LB'(wb_addr));
      end
      mem_resp  = 1'b1;
      mem_rdata = rand_line();
      tick();
      mem_resp  = 1'b0;
    end
    chk("fill_mem_read", LB'(mem_read), LB'(1));
    chk("fill_mem_write", LB'(mem_write), '0);
    chk("fill_mem_addr", LB'(mem_addr), LB'(fill_addr));
    for (int i = 0; i < v.delay; i++) begin
      tick();
      chk("fill_hold", LB'({mem_write, mem_read}), LB'(2'b01));
      chk("fill_hold_busy", LB'(busy), LB'(1));
    end
    mem_resp  = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_resp  = 1'b0;
    req_valid = 1'b0;
    req_miss  = 1'b0;
    mem_rdata = rand_line();
    chk("inst_fill_we", LB'(fill_we), LB'(v.exp_we));
    chk("inst_fill_way", LB'(fill_way), LB'(v.way));
    chk("inst_fill_set", LB'(fill_set), LB'(v.set));
    chk("inst_fill_tag", LB'(fill_tag), LB'(v.tag));
    chk("inst_fill_data", fill_data, rdata);
    chk("inst_fill_done", LB'(fill_done), LB'(1));
    chk("inst_busy", LB'(busy), LB'(1));
    chk("inst_mem_req", LB'({mem_write, mem_read}), '0);
    tick();
    chk("post_busy", LB'(busy), '0);
    chk("post_fill_we", LB'(fill_we), '0);
    chk("post_fill_done", LB'(fill_done), '0);
  endtask

  vec_t vecs[5];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_miss = 1'b0; req_addr = '0;
    evict_way = '0; evict_we = 8'b1; victim_dirty = 1'b0; victim_tag = '0;
    victim_data = '0; mem_rdata = '0; mem_resp = 1'b0;

    vecs[0] = '{6'd5,  21'h00123,  3'd3, 3'd3, 1'b0, 21'h0,    0, 3, 8'b0000_1000};
    vecs[1] = '{6'd5,  21'h00456,  3'd3, 3'd1, 1'b1, 21'h0001A, 2, 1, 8'b0000_1000};
    vecs[2] = '{6'd9,  21'h0BEEF,  3'd3, 3'd6, 1'b0, 21'h0,    0, 2, 8'b0000_1000};
    vecs[3] = '{6'd0,  21'h1FFFFF, 3'd7, 3'd0, 1'b1, 21'h1FFFFF, 0, 0, 8'b1000_0000};
    vecs[4] = '{6'd63, 21'h00001,  3'd0, 3'd5, 1'b1, 21'h0001A, 3, 0, 8'b0000_0001};

    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk_all_zero("idle");

    foreach (vecs[i]) do_miss(vecs[i]);

    // Reset while FILL is pending, then a late response must be dropped.
    req_valid = 1'b1; req_miss = 1'b1; req_addr = {21'h00777, 6'd12, 5'd0};
    evict_way = 3'd2; evict_we = 8'b0000_0100; victim_dirty = 1'b0;
    tick();
    req_valid = 1'b0; req_miss = 1'b0;
    chk("rst_pre_read", LB'(mem_read), LB'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("rst_mid");
    mem_resp = 1'b1; mem_rdata = rand_line();
    tick();
    mem_resp = 1'b0;
    chk("rst_drop_we", LB'(fill_we), '0);
    chk("rst_drop_busy", LB'(busy), '0);
    chk("rst_drop_done", LB'(fill_done), '0);
    do_miss(vecs[0]);

    // Back-to-back misses, then a stray response in IDLE.
    do_miss(vecs[1]);
    do_miss(vecs[2]);
    mem_resp = 1'b1; mem_rdata = rand_line();
    tick();
    mem_resp = 1'b0;
    chk("stray_busy", LB'(busy), '0);
    chk("stray_req", LB'({mem_write, mem_read}), '0);
    chk("stray_we", LB'(fill_we), '0);
    tick();
    chk("stray_busy2", LB'(busy), '0);
    chk("stray_done2", LB'(fill_done), '0);

    for (int n = 0; n < 40; n++) begin
      rv.set      = SB'($urandom);
      rv.tag      = TB'($urandom);
      rv.way      = WB'($urandom);
      rv.alt_way  = WB'($urandom);
      rv.dirty    = 1'($urandom);
      rv.vtag     = TB'($urandom);
      rv.wb_delay = int'($urandom_range(0, 3));
      rv.delay    = int'($urandom_range(0, 4));
      rv.exp_we   = 8'b1 << rv.way;
      do_miss(rv);
      if ($urandom_range(0, 3) == 0) begin
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        chk("rand_stray_busy", LB'(busy), '0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
